// File: rtl/client_req_collector.sv
// Collects one request bit per client into a registered request vector.
// Bit 0 is the AND of a slice of the owned bits. Summary and rising-edge outputs are also provided.
module client_req_collector #(
    parameter int unsigned NUM_CLIENTS = 8,
    parameter int unsigned AND_LO      = 1,
    parameter int unsigned AND_HI      = 4,
    parameter logic [NUM_CLIENTS-1:0] RESET_VALUE = 8'h54
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_CLIENTS-1:0]               client_we,
    input  logic [NUM_CLIENTS-1:0]               client_d,
    input  logic [NUM_CLIENTS-1:0]               client_toggle,
    output logic [NUM_CLIENTS-1:0]               req,
    output logic                                 req_any,
    output logic                                 req_all,
    output logic [$clog2(NUM_CLIENTS+1)-1:0]     req_count,
    output logic [NUM_CLIENTS-1:0]               req_rise
);

    localparam int unsigned CntW = $clog2(NUM_CLIENTS + 1);

    // prev_q must start at the value req takes out of reset, so req_rise stays low after reset.
    localparam logic [NUM_CLIENTS-1:0] ReqReset =
        {RESET_VALUE[NUM_CLIENTS-1:1], &RESET_VALUE[AND_HI:AND_LO]};

    logic [NUM_CLIENTS-1:1] own_q, own_d;
    logic [NUM_CLIENTS-1:0] prev_q, prev_d;
    logic                   and_bit;
    logic [CntW-1:0]        cnt;

    // A write takes priority over a toggle for the same bit.
    always_comb begin
        own_d = own_q;
        for (int i = 1; i < NUM_CLIENTS; i++) begin
            if (client_we[i]) begin
                own_d[i] = client_d[i];
            end else if (client_toggle[i]) begin
                own_d[i] = ~own_q[i];
            end
        end
    end

    assign and_bit = &own_q[AND_HI:AND_LO];
    assign req     = {own_q, and_bit};
    assign prev_d  = req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            own_q  <= RESET_VALUE[NUM_CLIENTS-1:1];
            prev_q <= ReqReset;
        end else begin
            own_q  <= own_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cnt = cnt + CntW'(req[i]);
        end
    end

    assign req_any   = |req;
    assign req_all   = &req;
    assign req_count = cnt;
    assign req_rise  = req & ~prev_q;

endmodule

// File: tb/tb_client_req_collector.sv
// Directed self-checking bench for client_req_collector with default parameters.
// Expected values are hand-computed constants and a small per-bit toggle model.
module tb_client_req_collector;

    logic       clock;
    logic       reset_n;
    logic [7:0] client_we;
    logic [7:0] client_d;
    logic [7:0] client_toggle;
    logic [7:0] req;
    logic       req_any;
    logic       req_all;
    logic [3:0] req_count;
    logic [7:0] req_rise;

    int n_checks = 0;
    int n_fail   = 0;

    client_req_collector #(
        .NUM_CLIENTS (8),
        .AND_LO      (1),
        .AND_HI      (4),
        .RESET_VALUE (8'h54)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .client_we     (client_we),
        .client_d      (client_d),
        .client_toggle (client_toggle),
        .req           (req),
        .req_any       (req_any),
        .req_all       (req_all),
        .req_count     (req_count),
        .req_rise      (req_rise)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] m_req;
    logic [7:0] m_prev;
    logic [7:0] tmask;

    initial begin
        reset_n       = 1'b0;
        client_we     = '0;
        client_d      = '0;
        client_toggle = '0;
        repeat (2) @(posedge clock);
        #1;

        // 1: reset state
        check_eq("rst_req",   req,       8'h54);
        check_eq("rst_count", req_count, 4'd3);
        check_eq("rst_any",   req_any,   1'b1);
        check_eq("rst_all",   req_all,   1'b0);
        check_eq("rst_rise",  req_rise,  8'h00);
        #2 reset_n = 1'b1;
        tick();
        check_eq("post_rst_req", req, 8'h54);

        // 2: toggle bits 1 and 3
        client_toggle = 8'b0000_1010;
        tick();
        client_toggle = '0;
        check_eq("tog_req",   req,       8'h5F);
        check_eq("tog_count", req_count, 4'd6);
        check_eq("tog_rise",  req_rise,  8'h0B);
        tick();
        check_eq("tog_rise_clear", req_rise, 8'h00);
        check_eq("tog_req_hold",   req,      8'h5F);

        // 3: write beats toggle on bit 3; bit 0 drops with it
        client_we     = 8'h08;
        client_d      = 8'h00;
        client_toggle = 8'h08;
        tick();
        client_we     = '0;
        client_toggle = '0;
        check_eq("wt_req",   req,      8'h56);
        check_eq("wt_bit0",  req[0],   1'b0);
        check_eq("wt_rise",  req_rise, 8'h00);

        // 4: bit 0 strobes have no effect
        client_we     = 8'h01;
        client_d      = 8'h01;
        client_toggle = 8'h01;
        tick();
        client_we     = '0;
        client_d      = '0;
        client_toggle = '0;
        check_eq("b0_req", req, 8'h56);

        // 5: write all ones, then async reset mid-cycle
        client_we = 8'hFE;
        client_d  = 8'hFE;
        tick();
        client_we = '0;
        client_d  = '0;
        check_eq("all_req",   req,       8'hFF);
        check_eq("all_all",   req_all,   1'b1);
        check_eq("all_count", req_count, 4'd8);
        check_eq("all_rise",  req_rise,  8'hA9);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_req",   req,       8'h54);
        check_eq("async_rise",  req_rise,  8'h00);
        check_eq("async_count", req_count, 4'd3);
        #2 reset_n = 1'b1;

        // 6: client i toggles every i cycles; model tracks the owned bits
        m_req  = 8'h54;
        m_prev = 8'h54;
        for (int c = 1; c <= 50; c++) begin
            tmask = '0;
            for (int i = 1; i < 8; i++) begin
                if (c % i == 0) tmask[i] = 1'b1;
            end
            client_toggle = tmask;
            tick();
            m_prev    = m_req;
            m_req     = m_req ^ tmask;
            m_req[0]  = &m_req[4:1];
            check_eq($sformatf("seq_req_%0d", c),  req,      {56'd0, m_req});
            check_eq($sformatf("seq_and_%0d", c),  req[0],   &req[4:1]);
            check_eq($sformatf("seq_rise_%0d", c), req_rise, {56'd0, m_req & ~m_prev});
        end
        client_toggle = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
